// File: rtl/residue7_pkg.sv
// -----------------------------------------------------------------------------
// residue7_pkg
// Shared types and helpers for the chunk-serial mod-7 residue engine.
//   r7_state_t : engine FSM states (idle / running / result held)
//   RES_W      : width of a canonical mod-7 residue (0..6)
//   mod7_fold  : reduces a 5-bit partial sum (0..20) to its canonical residue
// -----------------------------------------------------------------------------
package residue7_pkg;

   typedef enum logic [1:0] {
      R7_IDLE,
      R7_RUN,
      R7_DONE
   } r7_state_t;

   localparam int RES_W = 3;

   // Since 8 == 1 (mod 7), the upper bits s[4:3] carry weight 1. Folding them
   // onto s[2:0] gives at most 3 + 7 = 10, so one conditional -7 is enough to
   // land in 0..6.
   function automatic logic [RES_W-1:0] mod7_fold(input logic [4:0] s);
      logic [3:0] f;
      // NOTE: function and always_comb bodies use blocking '=' so each line
      // sees the value computed on the line above; flops use '<=' only.
      f = {2'b00, s[4:3]} + {1'b0, s[2:0]};
      return (f >= 4'd7) ? RES_W'(f - 4'd7) : RES_W'(f);
   endfunction

endpackage

// File: rtl/residue7_add3.sv
// -----------------------------------------------------------------------------
// residue7_add3
// Combinational canonical mod-7 sum of the running residue and two 3-bit
// operand digits.
// Ports:
//   acc  in  RES_W  running residue, always 0..6
//   a    in  RES_W  low digit of the current 6-bit chunk
//   b    in  RES_W  high digit of the current 6-bit chunk
//   sum  out RES_W  (acc + a + b) mod 7, always 0..6
// -----------------------------------------------------------------------------
module residue7_add3
   import residue7_pkg::*;
(
   input  logic [RES_W-1:0] acc,
   input  logic [RES_W-1:0] a,
   input  logic [RES_W-1:0] b,
   output logic [RES_W-1:0] sum
);

   // 6 + 7 + 7 = 20 fits in five bits.
   logic [4:0] s;

   assign s   = 5'(acc) + 5'(a) + 5'(b);
   assign sum = mod7_fold(s);

endmodule

// File: rtl/residue7_serial.sv
// -----------------------------------------------------------------------------
// residue7_serial
// Chunk-serial mod-7 residue engine. Accepts a DATA_W-bit operand over
// valid/ready, consumes it six bits (two 3-bit digits) per cycle, and returns
// the canonical residue 0..6 over valid/ready. Relies on 2^3 == 1 (mod 7):
// the residue is the sum of the operand's 3-bit digits, mod 7.
//
// Optional feature, macro RES7_CHECK_EN:
//   defined   - in_expected is captured with the operand (reduced mod 7) and
//               out_err flags a mismatch while the result is presented.
//   undefined - in_expected is ignored and out_err is tied low.
//
// Parameters:
//   DATA_W  operand width, non-zero multiple of 6 (default 48)
// Ports:
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous active-low reset
//   in_valid     in   1       operand valid
//   in_ready     out  1       engine can accept an operand (IDLE only)
//   in_data      in   DATA_W  operand, sampled only on the accept cycle
//   in_expected  in   3       expected residue (RES7_CHECK_EN only)
//   out_valid    out  1       result valid (DONE only)
//   out_ready    in   1       consumer accepts result
//   out_residue  out  3       in_data mod 7, always 0..6
//   out_err      out  1       residue mismatch flag (RES7_CHECK_EN only)
// -----------------------------------------------------------------------------
module residue7_serial
   import residue7_pkg::*;
#(
   parameter int DATA_W = 48
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [2:0]        in_expected,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        out_residue,
   output logic              out_err
);

   localparam int STEPS = DATA_W / 6;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   if ((DATA_W <= 0) || ((DATA_W % 6) != 0)) begin : g_bad_width
      $error("residue7_serial: DATA_W (%0d) must be a non-zero multiple of 6", DATA_W);
   end

   r7_state_t         state;
   r7_state_t         state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] op;
   logic [RES_W-1:0]  acc;
   logic [RES_W-1:0]  acc_nxt;
   logic              accept;
   logic              last_step;

   assign accept    = in_valid && (state == R7_IDLE);
   assign last_step = (state == R7_RUN) && (cnt == CNT_W'(STEPS - 1));

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= R7_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default before the case so
      // no path leaves a signal unassigned, which would infer a latch.
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         R7_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = R7_RUN;
         end
         R7_RUN: begin
            if (last_step) state_nxt = R7_DONE;
         end
         R7_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = R7_IDLE;
         end
         default: state_nxt = R7_IDLE;
      endcase
   end

   // ------------------------------------------------------------ datapath
   residue7_add3 u_add3 (
      .acc (acc),
      .a   (op[2:0]),
      .b   (op[5:3]),
      .sum (acc_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         acc <= '0;
         cnt <= '0;
      end else if (state == R7_RUN) begin
         acc <= acc_nxt;
         // The counter returns to zero together with the RUN -> DONE exit.
         cnt <= last_step ? '0 : cnt + 1'b1;
      end
   end

   // NOTE: op carries no reset: it is loaded on every accept before any
   // digit of it is consumed, so its power-up contents are never observed.
   always_ff @(posedge clk) begin
      if (accept) begin
         op <= in_data;
      end else if (state == R7_RUN) begin
         op <= op >> 6;
      end
   end

   // acc is frozen outside RUN, so the result holds while the consumer stalls.
   assign out_residue = acc;

`ifdef RES7_CHECK_EN
   logic [RES_W-1:0] exp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q <= '0;
      end else if (accept) begin
         // 7 is the only 3-bit value outside canonical form.
         exp_q <= (in_expected == 3'd7) ? 3'd0 : in_expected;
      end
   end

   assign out_err = (state == R7_DONE) && (acc != exp_q);
`else
   logic unused_expected;

   assign unused_expected = ^in_expected;
   assign out_err         = 1'b0;
`endif

endmodule
